// File: rtl/seq_counter.sv
// Programmable-range sequence counter: up-wrap, down-wrap, bounce and one-shot
// modes over [lo, hi], with load, enable, direction state and a terminal-count pulse.
module seq_counter #(
  parameter int              WIDTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tc,
  output logic             done,
  output logic             cfg_err
);

  localparam logic [1:0] ST_UP   = 2'd0;
  localparam logic [1:0] ST_DOWN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] MODE_UP      = 2'd0;
  localparam logic [1:0] MODE_DOWN    = 2'd1;
  localparam logic [1:0] MODE_BOUNCE  = 2'd2;
  localparam logic [1:0] MODE_ONESHOT = 2'd3;

  typedef struct packed {
    logic [WIDTH-1:0] cnt;
    logic [1:0]       st;
    logic             tc;
    logic             done;
  } step_t;

  logic [WIDTH-1:0] count_q, count_d;
  logic [1:0]       state_q, state_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  step_t            step;

  function automatic logic in_range(input logic [WIDTH-1:0] c,
                                    input logic [WIDTH-1:0] l,
                                    input logic [WIDTH-1:0] h);
    return (c >= l) && (c <= h);
  endfunction

  function automatic step_t step_up_wrap(input logic [WIDTH-1:0] c,
                                         input logic [WIDTH-1:0] l,
                                         input logic [WIDTH-1:0] h);
    step_t s;
    if (!in_range(c, l, h) || (c == h)) s.cnt = l;
    else                                s.cnt = c + 1'b1;
    s.st   = ST_UP;
    s.tc   = (s.cnt == h);
    s.done = 1'b0;
    return s;
  endfunction

  function automatic step_t step_down_wrap(input logic [WIDTH-1:0] c,
                                           input logic [WIDTH-1:0] l,
                                           input logic [WIDTH-1:0] h);
    step_t s;
    if (!in_range(c, l, h) || (c == l)) s.cnt = h;
    else                                s.cnt = c - 1'b1;
    s.st   = ST_DOWN;
    s.tc   = (s.cnt == l);
    s.done = 1'b0;
    return s;
  endfunction

  // Direction flips on the step that lands on a bound, so dir and tc line up
  // with the turnaround value; sitting on a bound already (load, mode change,
  // or lo==hi) turns around immediately.
  function automatic step_t step_bounce(input logic [WIDTH-1:0] c,
                                        input logic [1:0]       st,
                                        input logic [WIDTH-1:0] l,
                                        input logic [WIDTH-1:0] h);
    step_t s;
    s.done = 1'b0;
    s.tc   = 1'b0;
    s.st   = st;
    s.cnt  = c;
    if (!in_range(c, l, h)) begin
      s.cnt = l;
      s.st  = ST_UP;
      s.tc  = (l == h);
    end else if (st == ST_DOWN) begin
      if (c == l) begin
        s.cnt = (l == h) ? l : l + 1'b1;
        s.st  = ST_UP;
        s.tc  = (l == h);
      end else begin
        s.cnt = c - 1'b1;
        s.st  = (s.cnt == l) ? ST_UP : ST_DOWN;
        s.tc  = (s.cnt == l);
      end
    end else begin
      if (c == h) begin
        s.cnt = (l == h) ? h : h - 1'b1;
        s.st  = ST_DOWN;
        s.tc  = (l == h);
      end else begin
        s.cnt = c + 1'b1;
        s.st  = (s.cnt == h) ? ST_DOWN : ST_UP;
        s.tc  = (s.cnt == h);
      end
    end
    return s;
  endfunction

  function automatic step_t step_oneshot(input logic [WIDTH-1:0] c,
                                         input logic [1:0]       st,
                                         input logic             dn,
                                         input logic [WIDTH-1:0] l,
                                         input logic [WIDTH-1:0] h);
    step_t s;
    s.cnt  = c;
    s.st   = st;
    s.tc   = 1'b0;
    s.done = dn;
    if (st != ST_DONE) begin
      if (!in_range(c, l, h)) s.cnt = l;
      else if (c < h)         s.cnt = c + 1'b1;
      if (s.cnt == h) begin
        s.st   = ST_DONE;
        s.done = 1'b1;
        s.tc   = 1'b1;
      end else begin
        s.st   = ST_UP;
      end
    end
    return s;
  endfunction

  assign cfg_err = (lo > hi);

  always_comb begin
    step = '0;
    case (mode)
      MODE_UP:      step = step_up_wrap(count_q, lo, hi);
      MODE_DOWN:    step = step_down_wrap(count_q, lo, hi);
      MODE_BOUNCE:  step = step_bounce(count_q, state_q, lo, hi);
      MODE_ONESHOT: step = step_oneshot(count_q, state_q, done_q, lo, hi);
      default:      step = '0;
    endcase
  end

  always_comb begin
    count_d = count_q;
    state_d = state_q;
    done_d  = done_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = load_val;
      state_d = (mode == MODE_DOWN) ? ST_DOWN : ST_UP;
      done_d  = 1'b0;
    end else if (en) begin
      // An inverted range pins the count to lo and freezes the rest.
      if (cfg_err) begin
        count_d = lo;
      end else begin
        count_d = step.cnt;
        state_d = step.st;
        done_d  = step.done;
        tc_d    = step.tc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= RST_VAL;
      state_q <= ST_UP;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign dir   = (state_q != ST_DOWN);
  assign tc    = tc_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq_counter.sv
// Directed bench for seq_counter: a WIDTH=3 instance for the mode sequences and
// a WIDTH=4 instance for the full-range wrap.
module tb_seq_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en3, load3, dir3, tc3, done3, err3;
  logic [1:0] mode3;
  logic [2:0] lo3, hi3, lv3, count3;
  logic       en4, load4, dir4, tc4, done4, err4;
  logic [1:0] mode4;
  logic [3:0] lo4, hi4, lv4, count4;

  int n_tests = 0;
  int n_fail  = 0;

  seq_counter #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .en(en3), .mode(mode3), .lo(lo3), .hi(hi3),
    .load(load3), .load_val(lv3), .count(count3), .dir(dir3), .tc(tc3),
    .done(done3), .cfg_err(err3)
  );

  seq_counter #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en4), .mode(mode4), .lo(lo4), .hi(hi4),
    .load(load4), .load_val(lv4), .count(count4), .dir(dir4), .tc(tc4),
    .done(done4), .cfg_err(err4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk3(input string tag, input int c, input int d, input int t);
    check({tag, ".count"}, 32'(count3), 32'(c));
    check({tag, ".dir"},   32'(dir3),   32'(d));
    check({tag, ".tc"},    32'(tc3),    32'(t));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_w[7]  = '{3, 4, 5, 6, 7, 3, 4};
  int exp_bc[7] = '{3, 4, 5, 4, 3, 2, 3};
  int exp_bd[7] = '{1, 1, 0, 0, 0, 1, 1};
  int exp_bt[7] = '{0, 0, 1, 0, 0, 1, 0};
  int exp_dc[7] = '{5, 4, 3, 2, 1, 6, 5};
  int exp_fc[4] = '{14, 15, 0, 1};

  initial begin
    rst = 1'b1;
    en3 = 1'b1; load3 = 1'b0; mode3 = 2'd0; lo3 = 3'd3; hi3 = 3'd7; lv3 = 3'd0;
    en4 = 1'b0; load4 = 1'b0; mode4 = 2'd0; lo4 = 4'd0; hi4 = 4'd15; lv4 = 4'd0;

    // Out-of-range start, then wrap
    repeat (4) tick();
    chk3("reset", 0, 1, 0);
    check("reset.done", 32'(done3), 32'd0);
    check("reset.cfg_err", 32'(err3), 32'd0);
    check("reset.count4", 32'(count4), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk3($sformatf("wrap[%0d]", i), exp_w[i], 1, (exp_w[i] == 7) ? 1 : 0);
    end
    rst = 1'b1;
    #1;
    check("async_rst.count", 32'(count3), 32'd0);
    repeat (2) tick();
    check("rst_hold.count", 32'(count3), 32'd0);
    rst = 1'b0;
    tick();
    chk3("restart", 3, 1, 0);

    // Bounce
    en3 = 1'b0; mode3 = 2'd2; lo3 = 3'd2; hi3 = 3'd5; lv3 = 3'd2; load3 = 1'b1;
    tick();
    load3 = 1'b0;
    chk3("bnc_load", 2, 1, 0);
    en3 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk3($sformatf("bounce[%0d]", i), exp_bc[i], exp_bd[i], exp_bt[i]);
    end

    // One-shot
    en3 = 1'b0; mode3 = 2'd3; lo3 = 3'd0; hi3 = 3'd4; lv3 = 3'd0; load3 = 1'b1;
    tick();
    load3 = 1'b0;
    en3 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk3($sformatf("oneshot[%0d]", i), i, 1, (i == 4) ? 1 : 0);
      check($sformatf("oneshot[%0d].done", i), 32'(done3), (i == 4) ? 32'd1 : 32'd0);
    end
    repeat (2) begin
      tick();
      chk3("os_hold", 4, 1, 0);
      check("os_hold.done", 32'(done3), 32'd1);
    end
    lv3 = 3'd1; load3 = 1'b1;
    tick();
    load3 = 1'b0;
    chk3("os_reload", 1, 1, 0);
    check("os_reload.done", 32'(done3), 32'd0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk3($sformatf("os_again[%0d]", i), i, 1, (i == 4) ? 1 : 0);
      check($sformatf("os_again[%0d].done", i), 32'(done3), (i == 4) ? 32'd1 : 32'd0);
    end

    // Down-wrap and load/en collision
    en3 = 1'b0; mode3 = 2'd1; lo3 = 3'd1; hi3 = 3'd6; lv3 = 3'd6; load3 = 1'b1;
    tick();
    load3 = 1'b0;
    chk3("dn_load", 6, 0, 0);
    check("dn_load.done", 32'(done3), 32'd0);
    en3 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk3($sformatf("down[%0d]", i), exp_dc[i], 0, (i == 4) ? 1 : 0);
    end
    lv3 = 3'd3; load3 = 1'b1;
    tick();
    load3 = 1'b0;
    chk3("collide", 3, 0, 0);
    tick();
    chk3("collide_next", 2, 0, 0);

    // Degenerate range lo==hi in every mode
    mode3 = 2'd0; lo3 = 3'd4; hi3 = 3'd4;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk3($sformatf("deg_up[%0d]", i), 4, 1, 1);
    end
    check("deg.cfg_err", 32'(err3), 32'd0);
    mode3 = 2'd2;
    tick();
    chk3("deg_bnc0", 4, 0, 1);
    tick();
    chk3("deg_bnc1", 4, 1, 1);
    mode3 = 2'd1;
    tick();
    chk3("deg_dn", 4, 0, 1);
    mode3 = 2'd3;
    tick();
    chk3("deg_os", 4, 1, 1);
    check("deg_os.done", 32'(done3), 32'd1);

    // Inverted range leaves state and done alone
    mode3 = 2'd0; lo3 = 3'd6; hi3 = 3'd2;
    #1;
    check("inv.cfg_err", 32'(err3), 32'd1);
    tick();
    chk3("inv_step", 6, 1, 0);
    check("inv_step.done", 32'(done3), 32'd1);
    en3 = 1'b0;
    tick();
    chk3("inv_hold", 6, 1, 0);
    en3 = 1'b1; lo3 = 3'd1; hi3 = 3'd6;
    #1;
    check("valid.cfg_err", 32'(err3), 32'd0);
    tick();
    chk3("leave_done", 1, 1, 0);
    check("leave_done.done", 32'(done3), 32'd0);

    // Full range on the 4-bit instance
    lv4 = 4'd13; load4 = 1'b1;
    tick();
    load4 = 1'b0;
    check("full_load", 32'(count4), 32'd13);
    en4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("full[%0d].count", i), 32'(count4), 32'(exp_fc[i]));
      check($sformatf("full[%0d].tc", i), 32'(tc4), (exp_fc[i] == 15) ? 32'd1 : 32'd0);
    end
    check("full.cfg_err", 32'(err4), 32'd0);
    en4 = 1'b0;
    repeat (2) begin
      tick();
      check("full_freeze.count", 32'(count4), 32'd1);
      check("full_freeze.tc", 32'(tc4), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
